// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, NB_DATA data bits sent LSB first,
// optional odd/even parity bit, then NB_STOP stop bits at CLKS_PER_BIT clocks each.
//
// Handshake (valid/ready): a word transfers on a rising edge where i_valid and
// o_ready are both high. o_ready is high only in IDLE, and i_valid is ignored at
// any other time. i_data is captured on that edge, so later changes to it do not
// affect the frame in flight. o_ready rises together with the one-cycle o_done
// pulse, so the next frame can start on the following edge.
//
// o_state exposes the FSM state for debug: 0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP.
module uart_tx_cfg #(
  parameter int CLOCK_FREQ = 10000000,
  parameter int BAUD_RATE  = 115200,
  parameter int NB_DATA    = 8,
  parameter int PARITY     = 0,
  parameter int NB_STOP    = 1
) (
  input  logic               clock,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_valid,
  output logic               o_ready,
  output logic               o_data,
  output logic               o_busy,
  output logic               o_done,
  output logic [2:0]         o_state
);

  localparam int CLKS_PER_BIT = (CLOCK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(NB_DATA - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(NB_STOP - 1);

  // Reject unsupported frame formats when the design is elaborated.
  if (NB_DATA < 5 || NB_DATA > 9) begin : g_bad_nb_data
    $error("uart_tx_cfg: NB_DATA must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (NB_STOP != 1 && NB_STOP != 2) begin : g_bad_nb_stop
    $error("uart_tx_cfg: NB_STOP must be 1 or 2");
  end
  if (CLKS_PER_BIT < 1) begin : g_bad_rate
    $error("uart_tx_cfg: BAUD_RATE too high for CLOCK_FREQ");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [IDX_W-1:0]   idx, idx_next;
  logic [NB_DATA-1:0] data_q;
  logic               tx_q, tx_next;
  logic               done_q;
  logic               accept, bit_end, stop_end, parity_bit;

  assign accept     = (state == S_IDLE) && i_valid;
  assign bit_end    = (cnt == CNT_LAST);
  assign stop_end   = (state == S_STOP) && bit_end && (idx == STOP_LAST);
  assign parity_bit = (PARITY == 1) ? ~(^data_q) : (^data_q);

  // State register; reset aborts any frame immediately.
  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state: advance one bit period at a time; unknown encodings fall back to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (i_valid) state_next = S_START;
      S_START:  if (bit_end) state_next = S_DATA;
      S_DATA:   if (bit_end && idx == DATA_LAST)
                  state_next = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_next = S_STOP;
      S_STOP:   if (bit_end && idx == STOP_LAST) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // FSM-decoded outputs.
  always_comb begin
    o_ready = (state == S_IDLE);
    o_busy  = (state != S_IDLE);
    o_state = state;
  end

  // Datapath next values: counter and bit index restart on every state change,
  // and the line value is chosen for the bit that starts on this edge.
  always_comb begin
    cnt_next = '0;
    idx_next = '0;
    tx_next  = 1'b1;
    if (state_next == state && state != S_IDLE) begin
      cnt_next = bit_end ? '0 : cnt + 1'b1;
      idx_next = bit_end ? idx + 1'b1 : idx;
    end
    case (state_next)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = data_q[idx_next];
      S_PARITY: tx_next = parity_bit;
      default:  tx_next = 1'b1;
    endcase
  end

  // Datapath registers: registered line, end-of-frame pulse, word capture on accept.
  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt    <= '0;
      idx    <= '0;
      data_q <= '0;
      tx_q   <= 1'b1;
      done_q <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      idx    <= idx_next;
      tx_q   <= tx_next;
      done_q <= stop_end;
      if (accept) data_q <= i_data;
    end
  end

  assign o_data = tx_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: four instances (8N1, 8E1, 8O1, 7N2) share one
// clock and reset. Expected line sequences are written by hand, one character
// per bit period in transmission order.
module tb_uart_tx_cfg;

  localparam int CPB = 87;

  logic       clock;
  logic       rst_n;
  logic [8:0] din   [4];
  logic       valid [4];
  logic       rdy   [4];
  logic       tx    [4];
  logic       busy  [4];
  logic       done  [4];
  logic [2:0] st    [4];

  int n_checks = 0;
  int n_fail   = 0;

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  uart_tx_cfg u_8n1 (
    .clock(clock), .i_rst_n(rst_n), .i_data(din[0][7:0]), .i_valid(valid[0]),
    .o_ready(rdy[0]), .o_data(tx[0]), .o_busy(busy[0]), .o_done(done[0]), .o_state(st[0])
  );

  uart_tx_cfg #(.PARITY(2)) u_8e1 (
    .clock(clock), .i_rst_n(rst_n), .i_data(din[1][7:0]), .i_valid(valid[1]),
    .o_ready(rdy[1]), .o_data(tx[1]), .o_busy(busy[1]), .o_done(done[1]), .o_state(st[1])
  );

  uart_tx_cfg #(.PARITY(1)) u_8o1 (
    .clock(clock), .i_rst_n(rst_n), .i_data(din[2][7:0]), .i_valid(valid[2]),
    .o_ready(rdy[2]), .o_data(tx[2]), .o_busy(busy[2]), .o_done(done[2]), .o_state(st[2])
  );

  uart_tx_cfg #(.NB_DATA(7), .NB_STOP(2)) u_7n2 (
    .clock(clock), .i_rst_n(rst_n), .i_data(din[3][6:0]), .i_valid(valid[3]),
    .o_ready(rdy[3]), .o_data(tx[3]), .o_busy(busy[3]), .o_done(done[3]), .o_state(st[3])
  );

  // Single comparison point
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Idle-line expectations for one instance
  task automatic idle_check(input int u, input string tag);
    check_val({tag, " tx"},    32'(tx[u]),   32'd1);
    check_val({tag, " ready"}, 32'(rdy[u]),  32'd1);
    check_val({tag, " busy"},  32'(busy[u]), 32'd0);
    check_val({tag, " done"},  32'(done[u]), 32'd0);
    check_val({tag, " state"}, 32'(st[u]),   32'd0);
  endtask

  // Driver: present a word at a falling edge, let the next rising edge accept it
  task automatic send(input int u, input logic [8:0] word);
    @(negedge clock);
    valid[u] = 1'b1;
    din[u]   = word;
    @(posedge clock);
    #1 valid[u] = 1'b0;
  endtask

  // Frame monitor: called just after the acceptance edge. Checks the first and last
  // cycle of every bit period, busy/ready during the frame, and the o_done cycle.
  // Returns at the falling edge inside the o_done cycle.
  task automatic check_frame(input int u, input string name, input string seq);
    int len;
    int b;
    int pos;
    logic exp_bit;
    len = seq.len() * CPB;
    @(negedge clock);
    for (int cyc = 0; cyc < len; cyc++) begin
      b   = cyc / CPB;
      pos = cyc % CPB;
      exp_bit = (seq[b] == 8'h31);
      if (pos == 0 || pos == CPB - 1)
        check_val($sformatf("%s bit%0d cyc%0d tx", name, b, pos), 32'(tx[u]), 32'(exp_bit));
      if (pos == 0) begin
        check_val($sformatf("%s bit%0d busy", name, b),  32'(busy[u]), 32'd1);
        check_val($sformatf("%s bit%0d ready", name, b), 32'(rdy[u]),  32'd0);
      end
      if (cyc == len - 1)
        check_val($sformatf("%s done early", name), 32'(done[u]), 32'd0);
      @(negedge clock);
    end
    check_val($sformatf("%s done pulse", name),  32'(done[u]), 32'd1);
    check_val($sformatf("%s ready at done", name), 32'(rdy[u]),  32'd1);
    check_val($sformatf("%s busy at done", name),  32'(busy[u]), 32'd0);
    check_val($sformatf("%s tx at done", name),    32'(tx[u]),   32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din[i]   = '0;
      valid[i] = 1'b0;
    end

    // Reset state of every instance
    repeat (2) @(negedge clock);
    for (int i = 0; i < 4; i++) idle_check(i, $sformatf("reset u%0d", i));

    // 8N1 0xA5, accepted on the very first edge after reset release
    @(negedge clock);
    rst_n    = 1'b1;
    valid[0] = 1'b1;
    din[0]   = 9'h0A5;
    @(posedge clock);
    #1 valid[0] = 1'b0;
    check_frame(0, "8n1 a5", "0101001011");
    @(negedge clock);
    idle_check(0, "8n1 after");

    // Even parity, 0xA5 -> parity 0
    send(1, 9'h0A5);
    check_frame(1, "8e1 a5", "01010010101");
    @(negedge clock);
    idle_check(1, "8e1 after");

    // Odd parity, 0xA5 -> parity 1
    send(2, 9'h0A5);
    check_frame(2, "8o1 a5", "01010010111");
    @(negedge clock);
    idle_check(2, "8o1 after");

    // 7 data bits, 2 stop bits, 0x55
    send(3, 9'h055);
    check_frame(3, "7n2 55", "0101010111");
    @(negedge clock);
    idle_check(3, "7n2 after");

    // Back-to-back: valid held high; data changes to 0x80 mid-frame
    @(negedge clock);
    valid[0] = 1'b1;
    din[0]   = 9'h001;
    @(posedge clock);
    fork
      check_frame(0, "b2b 01", "0100000001");
      begin
        repeat (300) @(negedge clock);
        din[0] = 9'h080;
      end
    join
    @(posedge clock);
    fork
      check_frame(0, "b2b 80", "0000000011");
      begin
        repeat (300) @(negedge clock);
        valid[0] = 1'b0;
      end
    join
    @(negedge clock);
    idle_check(0, "b2b after");

    // Reset during data bit 3 of 0xA5 (a 0 bit)
    send(0, 9'h0A5);
    repeat (CPB * 4 + 40) @(negedge clock);
    check_val("pre-reset tx", 32'(tx[0]), 32'd0);
    check_val("pre-reset busy", 32'(busy[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    idle_check(0, "async reset");
    repeat (3) begin
      @(negedge clock);
      check_val("in reset done", 32'(done[0]), 32'd0);
    end
    rst_n    = 1'b1;
    valid[0] = 1'b1;
    din[0]   = 9'h03C;
    @(posedge clock);
    #1 valid[0] = 1'b0;
    check_frame(0, "post-reset 3c", "0001111001");
    @(negedge clock);
    idle_check(0, "final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  CLOCK_FREQ  10000000  clock frequency in Hz
  BAUD_RATE   115200    line rate in bit/s
  NB_DATA     8         data bits per frame; legal range 5..9
  PARITY      0         parity mode: 0 none, 1 odd, 2 even
  NB_STOP     1         stop bits per frame; legal values 1 or 2
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clock    in   1        single clock; all logic on its rising edge
  i_rst_n  in   1        reset, asynchronous, active-low
  i_data   in   NB_DATA  parallel word to send
  i_valid  in   1        i_data is valid
  o_ready  out  1        transmitter can accept a word
  o_data   out  1        serial line; idles high
  o_busy   out  1        frame in progress
  o_done   out  1        one-cycle pulse at end of frame
REQ-003 Reset SHALL be asynchronous and active-low on i_rst_n, with one clock, clock; nothing else about reset or clocking is configurable.
REQ-004 Illegal values of NB_DATA, PARITY or NB_STOP SHALL be rejected at elaboration.

Function
REQ-005 CLKS_PER_BIT SHALL equal round(CLOCK_FREQ/BAUD_RATE), computed as (CLOCK_FREQ + BAUD_RATE/2)/BAUD_RATE; this gives 87 at the defaults.
REQ-006 The cycle counter SHALL be $clog2(CLKS_PER_BIT) bits wide, and the bit index $clog2(NB_DATA) bits wide (minimum 1).
REQ-007 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP; any unencoded state SHALL go to IDLE on the next clock.
REQ-008 Handshake: a word SHALL be accepted on a rising edge where i_valid and o_ready are both high; i_valid at any other time SHALL be ignored.
REQ-009 o_ready SHALL be high in IDLE only and low in every other state.
REQ-010 i_data SHALL be captured at the acceptance edge; later changes to i_data SHALL NOT affect the frame in flight.
REQ-011 o_data SHALL be registered, and SHALL go low on the acceptance edge itself (IDLE to START).
REQ-012 Every bit (start, data, parity, stop) SHALL hold o_data for exactly CLKS_PER_BIT cycles.
REQ-013 Data bits SHALL be sent LSB first.
REQ-014 Bit order SHALL be DATA to PARITY when PARITY is not 0, and DATA to STOP otherwise.
REQ-015 The parity bit SHALL be the XOR of all data bits for even parity, and its inverse for odd parity.
REQ-016 STOP SHALL drive 1 for NB_STOP*CLKS_PER_BIT cycles.
REQ-017 Total frame length SHALL be CLKS_PER_BIT*(1+NB_DATA+(PARITY!=0)+NB_STOP) cycles.
REQ-018 On the edge that ends STOP, the FSM SHALL return to IDLE and o_done SHALL be high for exactly that following cycle.
REQ-019 o_ready SHALL rise in that same cycle, so back-to-back frames are possible with no extra idle bit.
REQ-020 o_busy SHALL be high in every non-IDLE state.
REQ-021 Counter and bit index SHALL be zero on entry to each state.
REQ-022 o_data SHALL be 1 in IDLE.

Reset
REQ-023 While i_rst_n is low, the outputs SHALL be: state IDLE, o_data 1, o_ready 1, o_busy 0, o_done 0; counter, bit index and captured data SHALL all be 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately (o_data 1 without waiting for a clock); no o_done pulse SHALL follow.
REQ-025 After reset release, the first accept SHALL be possible on the first rising edge.

Verification
REQ-026 Defaults (8N1), i_data=0xA5 -> o_data sends 0, 1,0,1,0,0,1,0,1, then 1, each held 87 cycles; o_done pulses 870 cycles after acceptance.
REQ-027 PARITY=2, i_data=0xA5 -> parity bit 0; PARITY=1, same data -> parity bit 1; frame is 957 cycles.
REQ-028 NB_DATA=7, NB_STOP=2, i_data=7'h55 -> bits 0,1010101 (LSB first), then 1,1; frame is 870 cycles.
REQ-029 i_valid held high with 0x01 then 0x80 -> two frames back-to-back; second start bit begins on the o_done cycle edge; 0x80 is ignored while o_busy is high unless still asserted at o_ready.
REQ-030 i_rst_n pulsed low during data bit 3 -> o_data is 1 asynchronously, o_ready is 1, no o_done; a new frame with 0x3C then transmits correctly.
